// File: rtl/compare_arbiter.sv
// Round-robin arbiter that time-shares one W-bit magnitude comparator among NREQ requesters.
// Each served request costs three cycles: capture (grant), compare, done pulse.
module compare_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int W      = 4,
  parameter  int SIGNED = 0,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_bus,
  input  logic [NREQ*W-1:0] b_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              res_eq,
  output logic              res_gt,
  output logic              res_lt,
  output logic [IW-1:0]     res_id,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [W-1:0] SMASK = (SIGNED != 0) ? {1'b1, {(W-1){1'b0}}} : '0;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win_q;
  logic [W-1:0]    a_q, b_q;
  logic [NREQ-1:0] gnt_q, done_q;
  logic            eq_q, gt_q, lt_q, busy_q;
  logic [IW-1:0]   id_q;

  logic [IW-1:0]   win_d;
  logic [IW-1:0]   ptr_d;
  logic [IW:0]     scan_idx;
  logic            found;
  logic [NREQ-1:0] win_d_oh, win_q_oh;
  logic [W-1:0]    a_cmp, b_cmp;

  always_comb begin
    win_d    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (scan_idx >= (IW+1)'(NREQ)) begin
        scan_idx = scan_idx - (IW+1)'(NREQ);
      end
      if (!found && req[scan_idx[IW-1:0]]) begin
        found = 1'b1;
        win_d = scan_idx[IW-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign win_d_oh[gi] = (win_d == IW'(gi));
      assign win_q_oh[gi] = (win_q == IW'(gi));
    end
  endgenerate

  assign ptr_d = (win_q == IW'(NREQ-1)) ? '0 : win_q + 1'b1;
  assign a_cmp = a_q ^ SMASK;
  assign b_cmp = b_q ^ SMASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            win_q   <= win_d;
            a_q     <= a_bus[win_d*W +: W];
            b_q     <= b_bus[win_d*W +: W];
            gnt_q   <= win_d_oh;
            busy_q  <= 1'b1;
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          eq_q    <= (a_cmp == b_cmp);
          gt_q    <= (a_cmp >  b_cmp);
          lt_q    <= (a_cmp <  b_cmp);
          id_q    <= win_q;
          gnt_q   <= '0;
          done_q  <= win_q_oh;
          state_q <= S_DONE;
        end
        S_DONE: begin
          ptr_q   <= ptr_d;
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign res_eq = eq_q;
  assign res_gt = gt_q;
  assign res_lt = lt_q;
  assign res_id = id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: unsigned and signed instances share stimulus,
// expected results are queued at drive time and popped when done pulses.
module tb_compare_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] a_bus, b_bus;

  logic [NREQ-1:0] gnt_u, done_u, gnt_s, done_s;
  logic            eq_u, gt_u, lt_u, busy_u;
  logic            eq_s, gt_s, lt_s, busy_s;
  logic [1:0]      res_id_u, res_id_s;

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  compare_arbiter #(.NREQ(NREQ), .W(W), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt_u), .done(done_u), .res_eq(eq_u), .res_gt(gt_u), .res_lt(lt_u),
    .res_id(res_id_u), .busy(busy_u)
  );

  compare_arbiter #(.NREQ(NREQ), .W(W), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt_s), .done(done_s), .res_eq(eq_s), .res_gt(gt_s), .res_lt(lt_s),
    .res_id(res_id_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Returns {eq, gt, lt}
  function automatic logic [2:0] ref_flags(input logic [3:0] a, input logic [3:0] b, input bit sgn);
    if (sgn) return {$signed(a) == $signed(b), $signed(a) > $signed(b), $signed(a) < $signed(b)};
    return {a == b, a > b, a < b};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_u != 0) begin
      if (q.size() == 0) begin
        chk("done_unexpected", 32'(done_u), 0);
      end else begin
        e = q.pop_front();
        chk("done_u", 32'(done_u), 1 << e.id);
        chk("res_id_u", 32'(res_id_u), e.id);
        chk("flags_u", 32'({eq_u, gt_u, lt_u}), 32'(ref_flags(e.a, e.b, 1'b0)));
        chk("done_s", 32'(done_s), 1 << e.id);
        chk("res_id_s", 32'(res_id_s), e.id);
        chk("flags_s", 32'({eq_s, gt_s, lt_s}), 32'(ref_flags(e.a, e.b, 1'b1)));
      end
    end
  end

  task automatic wait_gnt();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (gnt_u == 0 && n < 20);
    if (gnt_u == 0) chk("gnt_timeout", 32'(gnt_u != 0), 1);
  endtask

  task automatic do_one(input int id, input logic [3:0] a, input logic [3:0] b,
                        input bit chg, input logic [3:0] a2);
    a_bus[id*W +: W] = a;
    b_bus[id*W +: W] = b;
    q.push_back('{id: id, a: a, b: b});
    req = 4'(1 << id);
    wait_gnt();
    chk("gnt", 32'(gnt_u), 1 << id);
    chk("busy_gnt", 32'(busy_u), 1);
    chk("done_in_gnt", 32'(done_u), 0);
    req = '0;
    if (chg) a_bus[id*W +: W] = a2;
    @(posedge clk); #1;
    chk("gnt_clear", 32'(gnt_u), 0);
    chk("busy_done", 32'(busy_u), 1);
    chk("done_pulse", 32'(done_u), 1 << id);
    @(posedge clk); #1;
    chk("done_clear", 32'(done_u), 0);
    chk("busy_idle", 32'(busy_u), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_cyc;
    rst_n = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    #12;
    chk("rst_gnt", 32'(gnt_u), 0);
    chk("rst_done", 32'(done_u), 0);
    chk("rst_flags", 32'({eq_u, gt_u, lt_u}), 0);
    chk("rst_id", 32'(res_id_u), 0);
    chk("rst_busy", 32'(busy_u), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, equal operands; flags must hold afterwards
    do_one(0, 4'd5, 4'd5, 1'b0, 4'd0);
    @(posedge clk); #1;
    chk("hold_flags", 32'({eq_u, gt_u, lt_u}), 32'b100);

    // Fairness from pointer 0 with all requests held
    do_reset();
    a_bus = {4'd0, 4'd15, 4'd8, 4'd3};
    b_bus = {4'd7, 4'd1,  4'd2, 4'd3};
    for (int k = 0; k < 5; k++) begin
      q.push_back('{id: k % 4, a: a_bus[(k%4)*W +: W], b: b_bus[(k%4)*W +: W]});
    end
    req = 4'hF;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      chk("rr_gnt", 32'(gnt_u), 1 << (k % 4));
      if (k > 0) chk("rr_spacing", cyc - last_cyc, 3);
      last_cyc = cyc;
      if (k == 4) req = '0;
    end
    @(posedge clk); @(posedge clk); #1;

    // Serve 2 so the pointer sits at 3, then 0 and 1 request together
    do_one(2, 4'd6, 4'd6, 1'b0, 4'd0);
    a_bus[0*W +: W] = 4'd1;  b_bus[0*W +: W] = 4'd2;
    a_bus[1*W +: W] = 4'd14; b_bus[1*W +: W] = 4'd14;
    q.push_back('{id: 0, a: 4'd1, b: 4'd2});
    q.push_back('{id: 1, a: 4'd14, b: 4'd14});
    req = 4'b0011;
    wait_gnt();
    chk("wrap_gnt0", 32'(gnt_u), 1);
    last_cyc = cyc;
    req = 4'b0010;
    wait_gnt();
    chk("wrap_gnt1", 32'(gnt_u), 2);
    chk("wrap_spacing", cyc - last_cyc, 3);
    req = '0;
    @(posedge clk); @(posedge clk); #1;

    // Compare semantics, then operand change after capture
    do_one(0, 4'd9, 4'd3,  1'b0, 4'd0);
    do_one(1, 4'd0, 4'd15, 1'b0, 4'd0);
    do_one(2, 4'd12, 4'd4, 1'b1, 4'd1);
    chk("chg_gt", 32'(gt_u), 1);
    chk("chg_id", 32'(res_id_u), 2);

    // Reset while in COMPARE
    a_bus[0*W +: W] = 4'd7; b_bus[0*W +: W] = 4'd1;
    req = 4'b0001;
    wait_gnt();
    chk("mid_gnt", 32'(gnt_u), 1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("mid_gnt_clr", 32'(gnt_u), 0);
    chk("mid_flags", 32'({eq_u, gt_u, lt_u}), 0);
    chk("mid_flags_s", 32'({eq_s, gt_s, lt_s}), 0);
    chk("mid_id", 32'(res_id_u), 0);
    chk("mid_busy", 32'(busy_u), 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("mid_no_done", 32'(done_u), 0);
    end
    rst_n = 1'b1;
    do_one(2, 4'd2, 4'd9, 1'b0, 4'd0);

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
